// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA pixel pipeline.
//   mode_e   : output pattern selector (frame buffer, colour bars, solid, grid)
//   BAR_LUT  : per-bar {B,G,R} channel enables for the 8-bar test pattern,
//              index 0 is the leftmost bar
//   total()  : sums the four segments of a horizontal or vertical timing
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_FB    = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  // Listed from bar 7 down to bar 0 because element [7] of a packed array is
  // written first: black, blue, red, magenta, green, cyan, yellow, white.
  localparam logic [7:0][2:0] BAR_LUT = {
    3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111
  };

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// ---------------------------------------------------------------------------
// vga_timing_counter
// Raster counters and stage-0 timing flags.
//   i_clock   : pixel clock
//   i_reset   : synchronous active-high reset, counters return to (0,0)
//   o_h_cnt   : horizontal position, 0..H_TOTAL-1
//   o_v_cnt   : vertical position, 0..V_TOTAL-1
//   o_active  : current position lies in the visible area
//   o_hs_raw  : position lies in the horizontal sync interval (active-high)
//   o_vs_raw  : line lies in the vertical sync interval (active-high)
//   o_frame   : position is (0,0), first pixel of a frame
// ---------------------------------------------------------------------------
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int CNT_W  = 12
) (
  input  logic             i_clock,
  input  logic             i_reset,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_active,
  output logic             o_hs_raw,
  output logic             o_vs_raw,
  output logic             o_frame
);

  localparam int H_TOTAL  = total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = total(V_ACT, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACT + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACT + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_last;
  logic             w_v_last;

  assign w_h_last = (r_h_cnt == CNT_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_active = (r_h_cnt < CNT_W'(H_ACT)) && (r_v_cnt < CNT_W'(V_ACT));
  assign o_hs_raw = (r_h_cnt >= CNT_W'(HS_START)) && (r_h_cnt <= CNT_W'(HS_END));
  assign o_vs_raw = (r_v_cnt >= CNT_W'(VS_START)) && (r_v_cnt <= CNT_W'(VS_END));
  assign o_frame  = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_pixel_pipeline.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipeline
// VGA timing generator and pixel output stage. Issues one frame-buffer read
// per visible pixel, carries that pixel's timing flags alongside the read so
// they meet the returned data, selects the pattern and registers the pins.
// Counter state to pins latency is RD_LATENCY+1 for every output.
//   clock, reset   : pixel clock, synchronous active-high reset
//   mode           : 0 frame buffer, 1 colour bars, 2 solid, 3 grid
//                    (takes effect at the next frame start)
//   solid_color    : {B,G,R} colour for solid mode
//   fb_req         : read strobe, one per visible pixel
//   fb_x, fb_y     : coordinate of the current read (0 when idle)
//   fb_data        : {B,G,R} returned exactly RD_LATENCY cycles after fb_req
//   VGA_R/G/B      : colour to the DAC
//   VGA_HS, VGA_VS : syncs with polarity HS_POL / VS_POL (0 = active-low)
//   VGA_BLANK_N    : high while the output pixel is visible
//   frame_start    : one-cycle pulse with output pixel (0,0)
// ---------------------------------------------------------------------------
module vga_pixel_pipeline
  import vga_pkg::*;
#(
  parameter int H_ACT      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACT      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_W    = 8,
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_color,
  output logic                 fb_req,
  output logic [CNT_W-1:0]     fb_x,
  output logic [CNT_W-1:0]     fb_y,
  input  logic [3*COLOR_W-1:0] fb_data,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 frame_start
);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // Everything the output stage needs to know about one pixel.
  typedef struct packed {
    logic             active;
    logic             hs;
    logic             vs;
    logic             frame;
    mode_e            mode;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } pix_t;

  // ---------------- stage 0: counters ----------------
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_active;
  logic             w_hs_raw;
  logic             w_vs_raw;
  logic             w_frame;

  vga_timing_counter #(
    .H_ACT (H_ACT),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP),
    .CNT_W (CNT_W)
  ) u_timing (
    .i_clock (clock),
    .i_reset (reset),
    .o_h_cnt (w_h_cnt),
    .o_v_cnt (w_v_cnt),
    .o_active(w_active),
    .o_hs_raw(w_hs_raw),
    .o_vs_raw(w_vs_raw),
    .o_frame (w_frame)
  );

  // The mode is latched at (0,0); that first pixel must already use the new
  // mode, so it takes the live input rather than the held copy.
  mode_e r_mode_q;
  mode_e w_mode_s0;

  assign w_mode_s0 = w_frame ? mode_e'(mode) : r_mode_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode_q <= MODE_FB;
    end else if (w_frame) begin
      r_mode_q <= mode_e'(mode);
    end
  end

  // The counters sit at (0,0) while reset is held, so the request is masked
  // to keep the frame buffer idle until the first real pixel.
  assign fb_req = w_active & ~reset;
  assign fb_x   = fb_req ? w_h_cnt : '0;
  assign fb_y   = fb_req ? w_v_cnt : '0;

  pix_t w_s0;

  always_comb begin
    w_s0        = '0;
    w_s0.active = w_active;
    w_s0.hs     = w_hs_raw;
    w_s0.vs     = w_vs_raw;
    w_s0.frame  = w_frame;
    w_s0.mode   = w_mode_s0;
    w_s0.x      = w_active ? w_h_cnt : '0;
    w_s0.y      = w_active ? w_v_cnt : '0;
  end

  // ---------------- delay line matching the read latency ----------------
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_dly
      pix_t r_stage;
      pix_t w_stage_in;

      if (gi == 0) begin : g_first
        assign w_stage_in = w_s0;
      end else begin : g_next
        assign w_stage_in = g_dly[gi-1].r_stage;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          r_stage <= '0;
        end else begin
          r_stage <= w_stage_in;
        end
      end
    end
  endgenerate

  pix_t w_end;
  assign w_end = g_dly[RD_LATENCY-1].r_stage;

  // ---------------- pattern select ----------------
  // bar = x*8/H_ACT; x < H_ACT for visible pixels so the quotient fits 3 bits.
  logic [2:0]           w_bar;
  logic [3*COLOR_W-1:0] w_rgb;

  assign w_bar = 3'({w_end.x, 3'b000} / (CNT_W + 3)'(H_ACT));

  always_comb begin
    w_rgb = '0;
    if (w_end.active) begin
      case (w_end.mode)
        MODE_FB:    w_rgb = fb_data;
        MODE_BARS:  w_rgb = {{COLOR_W{BAR_LUT[w_bar][2]}},
                             {COLOR_W{BAR_LUT[w_bar][1]}},
                             {COLOR_W{BAR_LUT[w_bar][0]}}};
        MODE_SOLID: w_rgb = solid_color;
        MODE_GRID:  w_rgb = ((w_end.x[4:0] == 5'd0) || (w_end.y[4:0] == 5'd0)) ? '1 : '0;
        default:    w_rgb = '0;
      endcase
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~HS_ACT;
      VGA_VS      <= ~VS_ACT;
      VGA_BLANK_N <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {VGA_B, VGA_G, VGA_R} <= w_rgb;
      VGA_HS      <= w_end.hs ? HS_ACT : ~HS_ACT;
      VGA_VS      <= w_end.vs ? VS_ACT : ~VS_ACT;
      VGA_BLANK_N <= w_end.active;
      frame_start <= w_end.frame;
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_pipeline
// Directed bench on a shrunken raster: H 8/2/3/3 (16 per line), V 4/1/2/1
// (8 lines, 128 cycles per frame), read latency 2, pin latency 3.
// The frame-buffer model answers each read with R = x + 16*y, G = ~R, B = C3.
// ---------------------------------------------------------------------------
module tb_vga_pixel_pipeline;

  localparam int CW = 8;
  localparam int CNT_W = 12;

  logic            clock;
  logic            reset;
  logic [1:0]      mode;
  logic [3*CW-1:0] solid_color;
  logic            fb_req;
  logic [CNT_W-1:0] fb_x;
  logic [CNT_W-1:0] fb_y;
  logic [3*CW-1:0] fb_data;
  logic [CW-1:0]   VGA_R;
  logic [CW-1:0]   VGA_G;
  logic [CW-1:0]   VGA_B;
  logic            VGA_HS;
  logic            VGA_VS;
  logic            VGA_BLANK_N;
  logic            frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  vga_pixel_pipeline #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(CW), .RD_LATENCY(2), .CNT_W(CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .solid_color(solid_color),
    .fb_req     (fb_req),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_data    (fb_data),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Frame-buffer model: two-cycle read latency.
  logic [CNT_W-1:0] fb_pix;
  logic [CW-1:0]    fb_d1;
  logic [CW-1:0]    fb_d2;
  assign fb_pix = fb_x + (fb_y << 4);
  always @(posedge clock) begin
    fb_d1 <= fb_req ? fb_pix[CW-1:0] : '0;
    fb_d2 <= fb_d1;
  end
  assign fb_data = {8'hC3, ~fb_d2, fb_d2};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    check_eq({tag, "_R"}, 32'(VGA_R), 32'(r));
    check_eq({tag, "_G"}, 32'(VGA_G), 32'(g));
    check_eq({tag, "_B"}, 32'(VGA_B), 32'(b));
  endtask

  initial begin
    int s;
    int hh;
    int vv;
    int exp_blank;

    reset       = 1'b1;
    mode        = 2'd0;
    solid_color = 24'h332211;

    // ---- reset state ----
    repeat (3) @(posedge clock);
    #2;
    check_eq("rst_fb_req", 32'(fb_req), 32'd0);
    check_eq("rst_fb_x", 32'(fb_x), 32'd0);
    check_eq("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
    check_eq("rst_hs", 32'(VGA_HS), 32'd1);
    check_eq("rst_vs", 32'(VGA_VS), 32'd1);
    check_eq("rst_frame_start", 32'(frame_start), 32'd0);
    check_rgb("rst", 8'h00, 8'h00, 8'h00);
    $display("[TB] reset state checked");

    reset = 1'b0;
    #1;  // cycle 0: counters at (0,0)

    // ---- frames 1-4: fb, solid, bars, grid ----
    for (int c = 0; c <= 420; c++) begin
      if (c > 0) tick();

      if (c < 32) begin
        check_eq($sformatf("fb_req@%0d", c), 32'(fb_req), 32'((c % 16) < 8));
        check_eq($sformatf("fb_x@%0d", c), 32'(fb_x), ((c % 16) < 8) ? 32'(c % 16) : 32'd0);
        check_eq($sformatf("fb_y@%0d", c), 32'(fb_y), ((c % 16) < 8) ? 32'(c / 16) : 32'd0);
        if (c >= 3) begin
          s  = c - 3;
          hh = s % 16;
          vv = s / 16;
          exp_blank = (hh < 8) ? 1 : 0;
          check_eq($sformatf("blank_n@%0d", c), 32'(VGA_BLANK_N), 32'(exp_blank));
          check_eq($sformatf("r@%0d", c), 32'(VGA_R), (exp_blank != 0) ? 32'(hh + 16 * vv) : 32'd0);
          check_eq($sformatf("hs@%0d", c), 32'(VGA_HS), (hh >= 10 && hh <= 12) ? 32'd0 : 32'd1);
          check_eq($sformatf("frame_start@%0d", c), 32'(frame_start), (s == 0) ? 32'd1 : 32'd0);
        end else begin
          check_eq($sformatf("blank_n@%0d", c), 32'(VGA_BLANK_N), 32'd0);
          check_eq($sformatf("r@%0d", c), 32'(VGA_R), 32'd0);
          check_eq($sformatf("hs@%0d", c), 32'(VGA_HS), 32'd1);
        end
      end

      case (c)
        5:   check_rgb("fb_pix2", 8'h02, 8'hFD, 8'hC3);
        20:  mode = 2'd2;  // solid, must wait for next frame
        38:  check_eq("fb_after_mode_change", 32'(VGA_R), 32'h23);
        82:  check_eq("vs@82", 32'(VGA_VS), 32'd1);
        83:  check_eq("vs@83", 32'(VGA_VS), 32'd0);
        114: check_eq("vs@114", 32'(VGA_VS), 32'd0);
        115: check_eq("vs@115", 32'(VGA_VS), 32'd1);
        128: begin
          check_eq("f2_fb_req", 32'(fb_req), 32'd1);
          check_eq("f2_fb_x", 32'(fb_x), 32'd0);
          check_eq("f2_fb_y", 32'(fb_y), 32'd0);
        end
        130: begin
          check_eq("f2_pre_frame_start", 32'(frame_start), 32'd0);
          check_eq("f2_pre_blank_n", 32'(VGA_BLANK_N), 32'd0);
        end
        131: begin
          check_eq("f2_frame_start", 32'(frame_start), 32'd1);
          check_rgb("solid_first", 8'h11, 8'h22, 8'h33);
        end
        140: mode = 2'd1;  // bars next frame
        149: check_rgb("solid_held", 8'h11, 8'h22, 8'h33);
        259: begin
          check_eq("f3_frame_start", 32'(frame_start), 32'd1);
          check_eq("bars_fb_req", 32'(fb_req), 32'd1);
          check_rgb("bar0_white", 8'hFF, 8'hFF, 8'hFF);
        end
        260: check_rgb("bar1_yellow", 8'hFF, 8'hFF, 8'h00);
        264: check_rgb("bar5_red", 8'hFF, 8'h00, 8'h00);
        266: begin
          check_rgb("bar7_black", 8'h00, 8'h00, 8'h00);
          check_eq("bar7_blank_n", 32'(VGA_BLANK_N), 32'd1);
        end
        267: check_eq("bars_blank_n", 32'(VGA_BLANK_N), 32'd0);
        270: mode = 2'd3;  // grid next frame
        387: check_rgb("grid_00", 8'hFF, 8'hFF, 8'hFF);
        389: check_eq("grid_x2y0", 32'(VGA_R), 32'hFF);
        403: check_eq("grid_x0y1", 32'(VGA_R), 32'hFF);
        406: begin
          check_rgb("grid_x3y1", 8'h00, 8'h00, 8'h00);
          check_eq("grid_x3y1_blank_n", 32'(VGA_BLANK_N), 32'd1);
        end
        default: ;
      endcase
    end
    $display("[TB] frames fb/solid/bars/grid checked, %0d tests so far", n_tests);

    // ---- fresh start, then reset at cycle 40 for two cycles ----
    reset = 1'b1;
    mode  = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("run2_fb_req@0", 32'(fb_req), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 13) check_eq("run2_hs@13", 32'(VGA_HS), 32'd0);
      if (c == 40) check_eq("run2_r@40", 32'(VGA_R), 32'h25);
    end
    reset = 1'b1;
    tick();  // cycle 41
    check_eq("midrst_hs", 32'(VGA_HS), 32'd1);
    check_eq("midrst_vs", 32'(VGA_VS), 32'd1);
    check_eq("midrst_blank_n", 32'(VGA_BLANK_N), 32'd0);
    check_eq("midrst_fb_req", 32'(fb_req), 32'd0);
    check_eq("midrst_frame_start", 32'(frame_start), 32'd0);
    check_rgb("midrst", 8'h00, 8'h00, 8'h00);
    tick();
    reset = 1'b0;
    #1;
    check_eq("restart_fb_req", 32'(fb_req), 32'd1);
    check_eq("restart_fb_x", 32'(fb_x), 32'd0);
    check_eq("restart_fb_y", 32'(fb_y), 32'd0);
    tick();
    tick();
    tick();  // cycle 3
    check_eq("restart_blank_n@3", 32'(VGA_BLANK_N), 32'd1);
    check_eq("restart_frame_start@3", 32'(frame_start), 32'd1);
    check_eq("restart_r@3", 32'(VGA_R), 32'd0);
    tick();
    tick();  // cycle 5
    check_eq("restart_r@5", 32'(VGA_R), 32'd2);
    $display("[TB] mid-frame reset and restart checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
